// File: rtl/sm3_core_arbiter.sv
// sm3_core_arbiter: round-robin sharing of one SM3 core among NREQ requesters.
// Optional WAIT-state watchdog when SM3_ARB_WATCHDOG_EN is defined.
module sm3_core_arbiter #(
  parameter int NREQ = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*512-1:0]  data_in,
  input  logic [NREQ*32-1:0]   append_in,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [255:0]         hash_out,
  output logic                 busy,
  output logic [511:0]         core_datain,
  output logic [31:0]          core_appendin,
  output logic                 core_start,
  input  logic [255:0]         core_hashout,
  input  logic                 core_valid
);
  localparam int W = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  state_t state, state_n;
  logic [W-1:0] ptr, ptr_n, owner, owner_n, win, nxt;
  logic found;
  logic [NREQ-1:0] ack_n, done_n;
  logic [255:0] hash_n;
  logic [511:0] dat_n;
  logic [31:0] app_n;
  logic start_n;
`ifdef SM3_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] wcnt, wcnt_n;
  logic [NREQ-1:0] err_n;
  logic tmo;
  assign tmo = wcnt == CW'(TIMEOUT_CYCLES - 1);
  assign wcnt_n = (state == LAUNCH) ? '0 : (state == WAIT) ? wcnt + 1'b1 : wcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      err <= '0;
    end else begin
      wcnt <= wcnt_n;
      err <= err_n;
    end
  end
`else
  assign err = '0;
`endif
  assign busy = state != IDLE;
  assign nxt = (owner == W'(NREQ - 1)) ? '0 : owner + 1'b1;
  // Lowest offset from ptr wins, so scan offsets downward and let later hits override.
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      if (req[(int'(ptr) + o) % NREQ]) begin
        win = W'((int'(ptr) + o) % NREQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    ack_n = '0;
    done_n = '0;
    hash_n = hash_out;
    dat_n = core_datain;
    app_n = core_appendin;
    start_n = 1'b0;
`ifdef SM3_ARB_WATCHDOG_EN
    err_n = '0;
`endif
    if (state == IDLE && found) begin
      owner_n = win;
      dat_n = data_in[512*win +: 512];
      app_n = append_in[32*win +: 32];
      ack_n[win] = 1'b1;
      start_n = 1'b1;
      state_n = LAUNCH;
    end else if (state == LAUNCH) begin
      state_n = WAIT;
    end else if (state == WAIT && core_valid) begin
      hash_n = core_hashout;
      done_n[owner] = 1'b1;
      ptr_n = nxt;
      state_n = IDLE;
`ifdef SM3_ARB_WATCHDOG_EN
    end else if (state == WAIT && tmo) begin
      err_n[owner] = 1'b1;
      ptr_n = nxt;
      state_n = IDLE;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      ack <= '0;
      done <= '0;
      hash_out <= '0;
      core_datain <= '0;
      core_appendin <= '0;
      core_start <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      ack <= ack_n;
      done <= done_n;
      hash_out <= hash_n;
      core_datain <= dat_n;
      core_appendin <= app_n;
      core_start <= start_n;
    end
  end
endmodule

// File: tb/tb_sm3_core_arbiter.sv
// tb_sm3_core_arbiter: scoreboard bench for sm3_core_arbiter with a 70-cycle SM3 core stub.
module tb_sm3_core_arbiter;
  logic clk = 0, rst = 1;
  logic [1:0] req = '0;
  logic [1023:0] data_in;
  logic [63:0] append_in;
  logic [1:0] ack, done, err;
  logic [255:0] hash_out, core_hashout;
  logic busy, core_start, core_valid;
  logic [511:0] core_datain;
  logic [31:0] core_appendin;
  logic stall = 0, expect_err = 0, prev_valid = 0;
  int checks = 0, errors = 0, cyc = 0, n_ack = 0, n_done = 0, n_err = 0;
  int ack_cyc = 0, done_cyc = 0, err_cyc = 0, cnt = 0;
  logic run;
  typedef struct {int o; logic [255:0] h;} exp_t;
  int exp_ack[$];
  exp_t exp_done[$];
  localparam logic [511:0] D0 = {16{32'h61626364}};
  localparam logic [511:0] D1 = {16{32'h89abcdef}};
  localparam logic [31:0] A0 = 32'h61626364;
  localparam logic [31:0] A1 = 32'hdeadbeef;
  localparam logic [255:0] H0 = {8{32'h61626364}};
  localparam logic [255:0] H1 = {32'hdeadbeef, {7{32'h89abcdef}}};
  logic [511:0] dd [2];
  logic [31:0] aa [2];
  assign data_in = {D1, D0};
  assign append_in = {A1, A0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm3_core_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .append_in(append_in),
    .ack(ack), .done(done), .err(err), .hash_out(hash_out), .busy(busy),
    .core_datain(core_datain), .core_appendin(core_appendin), .core_start(core_start),
    .core_hashout(core_hashout), .core_valid(core_valid)
  );

  // core stub: result {append, data[223:0]} about 70 cycles after start
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 0; cnt <= 0; core_valid <= 0; core_hashout <= '0;
    end else begin
      core_valid <= 0;
      if (core_start) begin
        run <= 1; cnt <= 0; core_hashout <= {core_appendin, core_datain[223:0]};
      end else if (run && !stall) begin
        if (cnt == 68) begin run <= 0; core_valid <= 1; end
        else cnt <= cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (core_start !== |ack) begin
        errors++; $display("FAIL start_with_ack: core_start=%0b ack=%b", core_start, ack);
      end
      checks++;
      if ($countones({ack, done, err}) > 1) begin
        errors++; $display("FAIL onehot: ack=%b done=%b err=%b want at most one bit", ack, done, err);
      end
      if (|ack) begin
        n_ack++; ack_cyc = cyc; checks++;
        if (exp_ack.size() == 0) begin
          errors++; $display("FAIL unexpected_ack: ack=%b want none", ack);
        end else begin
          int o;
          o = exp_ack.pop_front();
          if (ack !== 2'(1 << o) || core_datain !== dd[o] || core_appendin !== aa[o]) begin
            errors++; $display("FAIL ack_grant: ack=%b app=%h want owner %0d app=%h", ack, core_appendin, o, aa[o]);
          end
        end
      end
      if (|done) begin
        n_done++; done_cyc = cyc; checks++;
        if (exp_done.size() == 0 || !prev_valid) begin
          errors++; $display("FAIL unexpected_done: done=%b prev_valid=%0b", done, prev_valid);
        end else begin
          exp_t e;
          e = exp_done.pop_front();
          if (done !== 2'(1 << e.o) || hash_out !== e.h) begin
            errors++; $display("FAIL done_hash: done=%b hash=%h want owner %0d hash=%h", done, hash_out, e.o, e.h);
          end
        end
      end
      if (|err) begin
        n_err++; err_cyc = cyc;
        if (!expect_err) begin
          checks++; errors++; $display("FAIL unexpected_err: err=%b want 0", err);
        end
      end
      prev_valid = core_valid;
    end else prev_valid = 0;
  end

  task automatic wait_cnt(input int target, input bit is_done, input string nm);
    for (int i = 0; i < 400 && (is_done ? n_done : n_ack) < target; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if ((is_done ? n_done : n_ack) < target) begin
      errors++; $display("FAIL %s_timeout: count=%0d want %0d", nm, is_done ? n_done : n_ack, target);
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act !== want) begin
      errors++; $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  initial begin
    int na, nd;
    dd[0] = D0; dd[1] = D1; aa[0] = A0; aa[1] = A1;
    repeat (4) @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    chk("reset_flags", {ack, done, err, busy, core_start}, '0);
    chk("reset_hash", hash_out, '0);
    chk("reset_core_in", {core_datain[255:0] ^ core_datain[511:256], core_appendin}, '0);
    chk("reset_core_data", core_datain[255:0], '0);
    // single job
    exp_ack.push_back(0); exp_done.push_back('{0, H0});
    req = 2'b01;
    wait_cnt(1, 0, "single_ack");
    req = 0;
    wait_cnt(1, 1, "single_done");
    @(negedge clk); #1;
    chk("idle_keeps_data", core_datain[255:0], D0[255:0]);
    chk("idle_busy", busy, 0);
    // contention from reset
    rst = 1; @(negedge clk); rst = 0; #1;
    na = n_ack; nd = n_done;
    for (int i = 0; i < 4; i++) begin
      exp_ack.push_back(i % 2);
      exp_done.push_back('{i % 2, (i % 2) ? H1 : H0});
    end
    req = 2'b11;
    wait_cnt(na + 4, 0, "contend_ack");
    req = 0;
    wait_cnt(nd + 4, 1, "contend_done");
    // withdrawal, then held request acked right after done
    na = n_ack; nd = n_done;
    exp_ack.push_back(0); exp_done.push_back('{0, H0});
    req = 2'b01;
    wait_cnt(na + 1, 0, "wd_ack0");
    req = 0;
    repeat (10) @(negedge clk);
    req = 2'b10; @(negedge clk); req = 0;
    repeat (10) @(negedge clk);
    exp_ack.push_back(1); exp_done.push_back('{1, H1});
    req = 2'b10;
    wait_cnt(nd + 1, 1, "wd_done0");
    wait_cnt(na + 2, 0, "wd_ack1");
    req = 0;
    chk("ack_after_done", 256'(ack_cyc - done_cyc), 256'd1);
    wait_cnt(nd + 2, 1, "wd_done1");
    // stalled core
    stall = 1;
    na = n_ack; nd = n_done;
    exp_ack.push_back(0);
    req = 2'b01;
    wait_cnt(na + 1, 0, "stall_ack");
    req = 0;
`ifdef SM3_ARB_WATCHDOG_EN
    expect_err = 1;
    for (int i = 0; i < 100 && n_err == 0; i++) begin @(negedge clk); #1; end
    chk("err_seen", 256'(n_err), 256'd1);
    chk("err_timing", 256'(err_cyc - ack_cyc), 256'd17);
    chk("err_hash_kept", hash_out, H1);
    expect_err = 0; stall = 0;
    exp_ack.push_back(0); exp_done.push_back('{0, H0});
    req = 2'b01;
    wait_cnt(na + 2, 0, "post_err_ack");
    req = 0;
    chk("post_err_ack_cyc", 256'(ack_cyc - err_cyc), 256'd1);
    wait_cnt(nd + 1, 1, "post_err_done");
    stall = 1;
    exp_ack.push_back(0);
    req = 2'b01;
    wait_cnt(na + 3, 0, "stall2_ack");
    req = 0;
    repeat (10) @(negedge clk);
`else
    repeat (200) @(negedge clk);
`endif
    #1;
    chk("stall_busy", busy, 1);
    nd = n_done;
    rst = 1; repeat (2) @(negedge clk); rst = 0; stall = 0; #1;
    chk("rst_mid_wait_idle", busy, 0);
    repeat (100) @(negedge clk); #1;
    chk("rst_no_done_err", {256'(n_done - nd) , 8'(n_err)}, '0);
    chk("queues_empty", 256'(exp_ack.size() + exp_done.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
